// File: rtl/mult_product_accumulator.sv
// Issues operand pairs to a fixed-latency signed multiplier, tags them through a matching pipe,
// and sums each op_last-delimited group of products into a saturating accumulator.
//   state | meaning
//   ACCUM | accepting operand pairs of the open group
//   DRAIN | last pair issued, waiting for its tag to retire
//   HOLD  | group result presented on acc_*, waiting for acc_ready
module mult_product_accumulator #(
  parameter int PROD_WIDTH = 64,
  parameter int ACC_WIDTH  = 72,
  parameter int LATENCY    = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  input  logic                  op_last,
  output logic                  op_ready,
  output logic                  issue,
  input  logic [PROD_WIDTH-1:0] product,
  output logic                  acc_valid,
  input  logic                  acc_ready,
  output logic [ACC_WIDTH-1:0]  acc_data,
  output logic [CNT_WIDTH-1:0]  acc_count,
  output logic                  acc_overflow
);

  localparam int EXT = ACC_WIDTH + 1 - PROD_WIDTH;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

  state_t state, state_nxt;

  logic [LATENCY-1:0]   tag_valid, tag_last;
  logic                 ret_valid, ret_last;
  logic [ACC_WIDTH-1:0] acc, sum_sat;
  logic [ACC_WIDTH:0]   sum_wide;
  logic [CNT_WIDTH-1:0] cnt, cnt_inc;
  logic                 grp_ovf, add_ovf;

  assign ret_valid = tag_valid[LATENCY-1];
  assign ret_last  = tag_last[LATENCY-1];
  assign issue     = op_valid & op_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (issue && op_last)      state_nxt = DRAIN;
      DRAIN:   if (ret_valid && ret_last) state_nxt = HOLD;
      HOLD:    if (acc_ready)             state_nxt = ACCUM;
      default:                            state_nxt = ACCUM;
    endcase
  end

  // Both handshake outputs decode only the state register, so acc_ready never reaches op_ready.
  always_comb begin
    op_ready  = (state == ACCUM);
    acc_valid = (state == HOLD);
  end

  always_comb begin
    sum_wide = {acc[ACC_WIDTH-1], acc} + {{EXT{product[PROD_WIDTH-1]}}, product};
    add_ovf  = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    if (add_ovf) sum_sat = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    else         sum_sat = sum_wide[ACC_WIDTH-1:0];
    cnt_inc = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid    <= '0;
      tag_last     <= '0;
      acc          <= '0;
      cnt          <= '0;
      grp_ovf      <= 1'b0;
      acc_data     <= '0;
      acc_count    <= '0;
      acc_overflow <= 1'b0;
    end else begin
      tag_valid[0] <= issue;
      tag_last[0]  <= issue & op_last;
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_last[i]  <= tag_last[i-1];
      end
      if (ret_valid) begin
        if (ret_last) begin
          acc_data     <= sum_sat;
          acc_count    <= cnt_inc;
          acc_overflow <= grp_ovf | add_ovf;
          acc          <= '0;
          cnt          <= '0;
          grp_ovf      <= 1'b0;
        end else begin
          acc     <= sum_sat;
          cnt     <= cnt_inc;
          grp_ovf <= grp_ovf | add_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Bench for mult_product_accumulator: a 72-bit and a 64-bit accumulator share one stimulus stream
// and a modelled 2-cycle multiplier; group results are checked against scoreboard queues.
module tb_mult_product_accumulator;

  localparam int MIN32 = -2147483647 - 1;

  typedef struct {
    logic [71:0] d;
    logic [7:0]  c;
    logic        o;
  } res_t;

  logic        clk = 1'b0;
  logic        rst, op_valid, op_last, acc_ready;
  int          a_op, b_op;
  logic [63:0] p1, product;

  logic        op_ready72, issue72, acc_valid72, acc_ovf72;
  logic [71:0] acc_data72;
  logic [7:0]  acc_count72;
  logic        op_ready64, issue64, acc_valid64, acc_ovf64;
  logic [63:0] acc_data64;
  logic [7:0]  acc_count64;

  res_t q72[$];
  res_t q64[$];
  int   n_pass = 0, n_total = 0, n_sent = 0, n_iss72 = 0, n_iss64 = 0;
  int   n;

  mult_product_accumulator u72 (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_last(op_last), .op_ready(op_ready72),
    .issue(issue72), .product(product), .acc_valid(acc_valid72), .acc_ready(acc_ready),
    .acc_data(acc_data72), .acc_count(acc_count72), .acc_overflow(acc_ovf72)
  );

  mult_product_accumulator #(.ACC_WIDTH(64)) u64 (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_last(op_last), .op_ready(op_ready64),
    .issue(issue64), .product(product), .acc_valid(acc_valid64), .acc_ready(acc_ready),
    .acc_data(acc_data64), .acc_count(acc_count64), .acc_overflow(acc_ovf64)
  );

  always #5 clk = ~clk;

  // Multiplier model: multiplies every cycle, product appears two edges after the operands.
  always_ff @(posedge clk) begin
    p1      <= longint'(a_op) * longint'(b_op);
    product <= p1;
  end

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
  endtask

  task automatic expect_res(input logic [71:0] d72, input logic [63:0] d64, input logic [7:0] c,
                            input logic o72, input logic o64);
    q72.push_back('{d: d72, c: c, o: o72});
    q64.push_back('{d: 72'(d64), c: c, o: o64});
  endtask

  task automatic send(input int x, input int y, input logic last);
    int g;
    g        = 0;
    op_valid = 1'b1;
    op_last  = last;
    a_op     = x;
    b_op     = y;
    while (op_ready72 !== 1'b1 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 100) begin
      n_total++;
      $display("FAIL send timeout: op_ready 0 for %0d cycles, required 1", g);
    end
    @(posedge clk); #1;
    n_sent++;
    op_valid = 1'b0;
    op_last  = 1'b0;
    a_op     = int'($urandom);
    b_op     = int'($urandom);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (acc_valid72 !== 1'b1 && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (cycles >= 50) begin
      n_total++;
      $display("FAIL wait acc_valid: still 0 after %0d cycles, required 1", cycles);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && acc_valid72 === 1'b1 && acc_ready === 1'b1) begin
      if (q72.size() == 0) begin
        n_total++;
        $display("FAIL acc72 unexpected result: got 0x%0h, required none", acc_data72);
      end else begin
        res_t e;
        e = q72.pop_front();
        chk("acc72 data", acc_data72, e.d);
        chk("acc72 count", 72'(acc_count72), 72'(e.c));
        chk("acc72 overflow", 72'(acc_ovf72), 72'(e.o));
      end
    end
    if (rst === 1'b0 && acc_valid64 === 1'b1 && acc_ready === 1'b1) begin
      if (q64.size() == 0) begin
        n_total++;
        $display("FAIL acc64 unexpected result: got 0x%0h, required none", acc_data64);
      end else begin
        res_t e;
        e = q64.pop_front();
        chk("acc64 data", 72'(acc_data64), e.d);
        chk("acc64 count", 72'(acc_count64), 72'(e.c));
        chk("acc64 overflow", 72'(acc_ovf64), 72'(e.o));
      end
    end
    if (rst === 1'b0 && issue72 === 1'b1) n_iss72++;
    if (rst === 1'b0 && issue64 === 1'b1) n_iss64++;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_last = 1'b0; acc_ready = 1'b1; a_op = 0; b_op = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset op_ready", 72'(op_ready72), 72'd1);
    chk("reset op_ready64", 72'(op_ready64), 72'd1);
    chk("reset issue", 72'(issue72), 72'd0);
    chk("reset acc_valid", 72'(acc_valid72), 72'd0);
    chk("reset acc_data", acc_data72, 72'd0);
    chk("reset acc_count", 72'(acc_count72), 72'd0);
    chk("reset acc_overflow", 72'(acc_ovf72), 72'd0);

    // Back-to-back group, sum -32.
    expect_res(-72'sd32, -64'sd32, 8'd3, 1'b0, 1'b0);
    send(3, 4, 1'b0);
    send(-5, 6, 1'b0);
    send(7, -2, 1'b1);
    chk("t1 op_ready low after last", 72'(op_ready72), 72'd0);
    wait_valid(n);
    idle(1);
    chk("t1 acc_valid one cycle", 72'(acc_valid72), 72'd0);
    chk("t1 op_ready after handshake", 72'(op_ready72), 72'd1);

    // Single most-negative square; result visible LATENCY+1 cycles after issue.
    expect_res(72'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 8'd1, 1'b0, 1'b0);
    send(MIN32, MIN32, 1'b1);
    wait_valid(n);
    chk("t2 issue to acc_valid edges", 72'(n), 72'd2);
    idle(1);

    // Consumer stalls for 5 cycles.
    acc_ready = 1'b0;
    expect_res(72'd100, 64'd100, 8'd1, 1'b0, 1'b0);
    send(10, 10, 1'b1);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      chk("t3 acc_valid held", 72'(acc_valid72), 72'd1);
      chk("t3 acc_data held", acc_data72, 72'd100);
      chk("t3 op_ready low", 72'(op_ready72), 72'd0);
      idle(1);
    end
    acc_ready = 1'b1;
    idle(1);
    acc_ready = 1'b0;
    chk("t3 acc_valid after pulse", 72'(acc_valid72), 72'd0);
    chk("t3 op_ready after pulse", 72'(op_ready72), 72'd1);
    acc_ready = 1'b1;

    // Three products of 2^62: saturates only in the 64-bit instance; next group starts clean.
    expect_res(72'hC000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 8'd3, 1'b0, 1'b1);
    send(MIN32, MIN32, 1'b0);
    send(MIN32, MIN32, 1'b0);
    send(MIN32, MIN32, 1'b1);
    expect_res(72'd6, 64'd6, 8'd1, 1'b0, 1'b0);
    send(2, 3, 1'b1);

    // Same group as the first, with bubbles carrying junk operands.
    expect_res(-72'sd32, -64'sd32, 8'd3, 1'b0, 1'b0);
    send(3, 4, 1'b0);
    idle(1);
    send(-5, 6, 1'b0);
    idle(3);
    send(7, -2, 1'b1);

    // Reset with one product accumulated and one still in flight.
    send(100, 100, 1'b0);
    idle(3);
    send(50, 50, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t6 op_ready after reset", 72'(op_ready72), 72'd1);
    chk("t6 acc_data after reset", acc_data72, 72'd0);
    chk("t6 acc_count after reset", 72'(acc_count72), 72'd0);
    idle(3);
    expect_res(72'd1, 64'd1, 8'd1, 1'b0, 1'b0);
    send(1, 1, 1'b1);
    wait_valid(n);
    idle(4);

    chk("q72 drained", 72'(q72.size()), 72'd0);
    chk("q64 drained", 72'(q64.size()), 72'd0);
    chk("issue72 count", 72'(n_iss72), 72'(n_sent));
    chk("issue64 count", 72'(n_iss64), 72'(n_sent));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
